// File: rtl/reg_bank_rw.sv
// Register bank for the multicycle datapath: 2^ADDR_W registers with one
// synchronous write port, two combinational read ports with optional
// write-through bypass, and the A/B operand latches loaded between cycles.
// Register 0 always reads zero; the stack-pointer register resets to SP_RESET.
module reg_bank_rw #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned SP_INDEX = 29,
  parameter int unsigned SP_RESET = 227,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  input  logic              load_ab,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out
);

  localparam int unsigned NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];

  // A write to register 0 is discarded so it can never be observed.
  logic wr_en;
  logic hit1;
  logic hit2;

  assign wr_en = reg_write && (write_reg != '0);
  assign hit1  = BYPASS && wr_en && (write_reg == read_reg1);
  assign hit2  = BYPASS && wr_en && (write_reg == read_reg2);

  // Register file storage: reset image, then one write per edge.
  // NOTE: the array is reset element by element so no register ever holds X;
  // this keeps the bank in flops rather than a RAM macro, which is intended.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= (i == SP_INDEX) ? DATA_W'(SP_RESET) : '0;
      end
    end else if (wr_en) begin
      // NOTE: state updates use non-blocking assignment so every flop samples
      // pre-edge values, matching the hardware regardless of block ordering.
      regs[write_reg] <= write_data;
    end
  end

  // Read port 1: zero for index 0, bypassed write data on a same-cycle hit.
  // NOTE: the output is given a default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    read_data1 = '0;
    if (read_reg1 != '0) begin
      read_data1 = hit1 ? write_data : regs[read_reg1];
    end
  end

  // Read port 2: identical structure to port 1.
  always_comb begin
    read_data2 = '0;
    if (read_reg2 != '0) begin
      read_data2 = hit2 ? write_data : regs[read_reg2];
    end
  end

  // Operand latches capture the pre-edge (possibly bypassed) read values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_out <= '0;
      b_out <= '0;
    end else if (load_ab) begin
      a_out <= read_data1;
      b_out <= read_data2;
    end
  end

endmodule

// File: doc/reg_bank_rw.md
Name: reg_bank_rw

Overview:
- Register bank that receives the write-back value chosen by the register-source selector and serves the operand-read side of the multicycle datapath.
- 32 x 32-bit registers: one synchronous write port, two combinational read ports, plus the A/B operand latches the datapath loads between cycles.
- Register 0 is hardwired to zero. The stack-pointer register resets to the stack-base constant (227), the same value the write-back selector produces on select 0.

Parameters:
- DATA_W, 32, register and data width.
- ADDR_W, 5, register index width (2^ADDR_W registers).
- SP_INDEX, 29, index of the stack-pointer register.
- SP_RESET, 227, reset value of register SP_INDEX.
- BYPASS, 1, 1 = a read of a register being written in the same cycle returns write_data; 0 = it returns the stored value.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- reg_write  in  1  write enable for the write port.
- write_reg  in  ADDR_W  destination index.
- write_data  in  DATA_W  write-back value from the register-source selector.
- read_reg1  in  ADDR_W  source index, port 1.
- read_reg2  in  ADDR_W  source index, port 2.
- load_ab  in  1  capture read ports into the A/B latches.
- read_data1  out  DATA_W  combinational read, port 1.
- read_data2  out  DATA_W  combinational read, port 2.
- a_out  out  DATA_W  registered operand A.
- b_out  out  DATA_W  registered operand B.

Behaviour:
- Reset (async, takes effect immediately, independent of clk):
  - All registers are cleared to 0, except register SP_INDEX, which is set to SP_RESET.
  - a_out = 0 and b_out = 0.
  - While reset is held, writes and loads are ignored.
  - After reset deasserts, operation starts on the next rising edge. There is no partial-write state.
- Write:
  - On the rising edge with reg_write=1 and write_reg != 0, register[write_reg] <= write_data. Write latency is 1 cycle.
  - A write to index 0 is discarded; register 0 always reads 0.
- Read:
  - read_dataN = 0 when read_regN = 0; otherwise register[read_regN]. Purely combinational, 0-cycle latency.
  - Bypass (BYPASS=1): if reg_write=1, write_reg != 0 and write_reg == read_regN in the current cycle, read_dataN = write_data.
  - With BYPASS=0, the old stored value is returned until the edge.
  - Both ports may address the same register; both return identical data.
- A/B latches:
  - On the rising edge with load_ab=1: a_out <= read_data1 and b_out <= read_data2. These are the bypassed values when BYPASS=1.
  - With load_ab=0 they hold their value.
  - A latch load and a register write on the same edge are both performed. The latch captures the pre-edge read value (bypassed or not, per BYPASS).
- Simultaneous events: a write to SP_INDEX overrides nothing special; SP_INDEX is an ordinary register after reset.
- Index wrap: indices are exactly ADDR_W bits wide; there is no out-of-range case.
- No X propagation: every register has a defined reset value.

Test Plan:
- Assert reset mid-run after writing r5=0xDEADBEEF -> r5 reads 0, r29 reads 227, a_out=b_out=0 immediately (before the next edge).
- reg_write=1, write_reg=0, write_data=0xFFFFFFFF, then read_reg1=0 -> read_data1=0; load_ab -> a_out=0.
- Write r8=0x12345678 on edge N; read_reg1=read_reg2=8 at N+1 -> both ports = 0x12345678; with load_ab=1 at N+1, a_out=b_out=0x12345678 after edge N+1.
- BYPASS=1: read_reg2=9 while writing r9=0xA5A5A5A5, same cycle -> read_data2=0xA5A5A5A5 before the edge; load_ab=1 on that edge -> b_out=0xA5A5A5A5. Repeat with BYPASS=0 -> read_data2 and b_out return the old r9 value (0 after reset).
- Write r29=0x100, then reset -> r29 returns to 227; decrement-style write r29=223 -> read_data1(29)=223 next cycle.
- load_ab=0 for 3 cycles while r1 changes 1->2->3 with read_reg1=1 -> a_out holds the last captured value; read_data1 tracks each write one edge later.
